block_word_reader_512: RTL and testbench

//  Read side of the 512-bit block store. Captures one 512-bit message block from the

---
 rtl/block_word_reader_512.sv | 106 ++++++++++
 tb/tb_block_word_reader_512.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/block_word_reader_512.sv
// Captures one message block from the block store and streams it MSB-word first
// as WORD_W-bit words over a valid/ready handshake, pulsing done after the last word.
module block_word_reader_512 #(
  parameter  int BLOCK_W   = 512,
  parameter  int WORD_W    = 32,
  localparam int NUM_WORDS = BLOCK_W / WORD_W,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] block_in,
  output logic [WORD_W-1:0]  word_out,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [IDX_W-1:0]   word_idx,
  output logic               word_last,
  output logic               busy,
  output logic               done
);

  // state  | meaning
  // S_IDLE | waiting for start, nothing captured
  // S_SEND | presenting word idx_q from the top of the shift register
  // S_DONE | one-cycle completion pulse, block store may be rewritten
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               idx_is_last;

  assign idx_is_last = (idx_q == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = S_SEND;
        S_SEND:  if (word_ready && idx_is_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shift register and word index; abort discards whatever remains of the block.
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (abort) begin
      sr_d  = '0;
      idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_d  = block_in;
            idx_d = '0;
          end
        end
        S_SEND: begin
          if (word_ready) begin
            sr_d  = sr_q << WORD_W;
            idx_d = idx_is_last ? '0 : idx_q + 1'b1;
          end
        end
        default: begin
          sr_d  = sr_q;
          idx_d = idx_q;
        end
      endcase
    end
  end

  always_comb begin
    word_valid = (state_q == S_SEND);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    word_last  = (state_q == S_SEND) && idx_is_last;
    word_out   = sr_q[BLOCK_W-1 -: WORD_W];
    word_idx   = idx_q;
  end

endmodule

// File: tb/tb_block_word_reader_512.sv
// Randomized scoreboard bench for block_word_reader_512: a block-level model queues the
// expected words at capture time and a monitor compares every presented word and status.
module tb_block_word_reader_512;
  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;
  localparam int NW      = BLOCK_W / WORD_W;

  logic               CLK = 1'b0;
  logic               RST;
  logic               start;
  logic               abort;
  logic [BLOCK_W-1:0] block_in;
  logic [WORD_W-1:0]  word_out;
  logic               word_valid;
  logic               word_ready;
  logic [3:0]         word_idx;
  logic               word_last;
  logic               busy;
  logic               done;

  block_word_reader_512 dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .block_in   (block_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WORD_W +: WORD_W] = $urandom();
    return r;
  endfunction

  // Reference model: a block is a list of 16 words; streaming pops them in order.
  typedef enum {M_IDLE, M_SEND, M_DONE} mst_t;
  mst_t              mst = M_IDLE;
  bit                model_ok = 1'b0;
  bit                rst_prev = 1'b0;
  bit                abort_prev = 1'b0;
  logic [WORD_W-1:0] exp_q[$];

  always @(negedge CLK) begin
    if (model_ok) begin
      chk("word_valid", 32'(word_valid), 32'(mst == M_SEND));
      chk("busy", 32'(busy), 32'(mst != M_IDLE));
      chk("done", 32'(done), 32'(mst == M_DONE));
      if (mst == M_SEND) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'(0), 32'(1));
        end else begin
          chk("word_out", word_out, exp_q[0]);
          chk("word_idx", 32'(word_idx), 32'(NW - exp_q.size()));
          chk("word_last", 32'(word_last), 32'(exp_q.size() == 1));
        end
      end else begin
        chk("word_last_idle", 32'(word_last), 32'(0));
      end
      if (rst_prev) begin
        chk("reset_word_out", word_out, 32'(0));
        chk("reset_word_idx", 32'(word_idx), 32'(0));
      end
      if (abort_prev && !rst_prev) chk("abort_word_idx", 32'(word_idx), 32'(0));
    end

    rst_prev   = RST;
    abort_prev = abort;
    if (RST) begin
      model_ok = 1'b1;
      mst      = M_IDLE;
      exp_q.delete();
    end else if (model_ok) begin
      if (abort) begin
        mst = M_IDLE;
        exp_q.delete();
      end else begin
        case (mst)
          M_IDLE: begin
            if (start) begin
              for (int i = 0; i < NW; i++)
                exp_q.push_back(block_in[BLOCK_W-1-i*WORD_W -: WORD_W]);
              mst = M_SEND;
            end
          end
          M_SEND: begin
            if (word_ready) begin
              void'(exp_q.pop_front());
              if (exp_q.size() == 0) mst = M_DONE;
            end
          end
          default: mst = M_IDLE;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0; block_in = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    step();

    // "abc" padded block, consumer always ready
    block_in = {32'h61626380, {14{32'h0}}, 32'h00000018};
    start = 1'b1; word_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();

    // backpressure 1,0,0 with block_in changing every cycle after capture
    block_in = rand_block(); start = 1'b1; word_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      word_ready = (c % 3 == 0);
      block_in   = rand_block();
      step();
    end

    // start held through SEND and DONE: only IDLE starts capture
    word_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 25; c++) begin
      block_in = rand_block();
      step();
    end
    start = 1'b0;
    repeat (20) step();

    // abort at idx 9 together with a transfer, then a fresh block
    block_in = rand_block(); start = 1'b1; word_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (3) step();
    block_in = rand_block(); start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();

    // reset mid-stream at idx 5 with start asserted alongside
    block_in = rand_block(); start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    RST = 1'b1; start = 1'b1;
    repeat (2) step();
    RST = 1'b0; start = 1'b0;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      word_ready = $urandom_range(0, 1) != 0;
      RST        = ($urandom_range(0, 199) == 0);
      block_in   = rand_block();
      step();
    end
    RST = 1'b0; start = 1'b0; abort = 1'b0; word_ready = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
